// File: rtl/bsdeser_if.sv
// ============================================================================
// Module      : bsdeser_if
// Description : Serial-in / parallel-out bus bundle for the bsdeser block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bsdeser_if #(
  parameter int W = 16
);
  logic         din;
  logic         isync;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         dready;
  logic         ferr;
  logic         overrun;
  logic         clr_ovf;

  modport master (
    output din, isync, dready, clr_ovf,
    input  dout, dvalid, ferr, overrun
  );

  modport slave (
    input  din, isync, dready, clr_ovf,
    output dout, dvalid, ferr, overrun
  );
endinterface

`default_nettype wire

// File: rtl/bsdeser.sv
// ============================================================================
// Module      : bsdeser
// Description : LSB-first bit-serial to parallel deserializer with a one-entry
//               valid/ready output register, framing-error and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsdeser #(
  parameter int W = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  bsdeser_if.slave  bus
);
  localparam int             c_CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [W-1:0]    r_sr;
  logic [W-1:0]    r_dout;
  logic            r_dvalid;
  logic            r_ferr;
  logic            r_ovf;

  logic            w_start;
  logic            w_ferr_set;
  logic            w_shift;
  logic            w_last;
  logic [W-1:0]    w_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.isync) w_state_nxt = S_SHIFT;
      S_SHIFT: if (!bus.isync && (r_cnt == c_LAST)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // isync always starts a new frame; in SHIFT it also flags the discarded one.
  always_comb begin
    w_start    = bus.isync;
    w_ferr_set = (r_state == S_SHIFT) && bus.isync;
    w_shift    = (r_state == S_SHIFT) && !bus.isync;
    w_last     = w_shift && (r_cnt == c_LAST);
    w_word     = {bus.din, r_sr[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sr     <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set;

      if (w_start) begin
        r_sr  <= {bus.din, {(W-1){1'b0}}};
        r_cnt <= c_ONE;
      end else if (w_shift) begin
        r_sr  <= w_word;
        r_cnt <= w_last ? '0 : r_cnt + c_ONE;
      end

      if (w_last && (!r_dvalid || bus.dready)) begin
        r_dout   <= w_word;
        r_dvalid <= 1'b1;
      end else if (r_dvalid && bus.dready) begin
        r_dvalid <= 1'b0;
      end

      // A fresh drop wins over a clear on the same edge.
      if (w_last && r_dvalid && !bus.dready) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.dout    = r_dout;
  assign bus.dvalid  = r_dvalid;
  assign bus.ferr    = r_ferr;
  assign bus.overrun = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bsdeser.sv
// ============================================================================
// Module      : tb_bsdeser
// Description : Self-checking bench for bsdeser against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsdeser;
  localparam int W = 16;

  typedef struct {
    bit din;
    bit isync;
    bit dready;
    bit clr;
    bit rst;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  bsdeser_if #(.W(W)) bus ();

  bsdeser #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: bits are dropped into a word by index; a frame is done once W bits land.
  logic [W-1:0] m_acc, m_dout;
  int           m_idx;
  bit           m_in, m_dvalid, m_ferr, m_ovf;
  stim_t        q[$];

  task automatic model(input stim_t s);
    bit complete, drop;
    complete = 0;
    drop = 0;
    if (s.rst) begin
      m_acc = '0; m_dout = '0; m_idx = 0; m_in = 0;
      m_dvalid = 0; m_ferr = 0; m_ovf = 0;
    end else begin
      m_ferr = 0;
      if (s.isync) begin
        m_ferr = m_in;
        m_acc = '0;
        m_acc[0] = s.din;
        m_idx = 1;
        m_in = 1;
      end else if (m_in) begin
        m_acc[m_idx] = s.din;
        m_idx++;
        if (m_idx == W) begin
          complete = 1;
          m_in = 0;
        end
      end
      if (complete) begin
        if (!m_dvalid || s.dready) begin
          m_dout = m_acc;
          m_dvalid = 1;
        end else begin
          drop = 1;
        end
      end else if (m_dvalid && s.dready) begin
        m_dvalid = 0;
      end
      if (drop) m_ovf = 1;
      else if (s.clr) m_ovf = 0;
    end
  endtask

  task automatic tick(input stim_t s);
    bus.din = s.din; bus.isync = s.isync; bus.dready = s.dready;
    bus.clr_ovf = s.clr; reset = s.rst;
    @(posedge clk);
    model(s);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] word, input bit rdy, input bit clr);
    for (int i = 0; i < W; i++) q.push_back('{word[i], i == 0, rdy, clr, 1'b0});
  endtask

  task automatic push_idle(input int n, input bit rdy, input bit clr);
    for (int i = 0; i < n; i++) q.push_back('{1'($urandom), 1'b0, rdy, clr, 1'b0});
  endtask

  task automatic test_reset;
    q.delete();
    q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    foreach (q[i]) begin
      tick(q[i]);
      n_vec++;
      if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {(W+3)'(0)}) begin
        n_err++;
        $display("FAIL reset: dout=%h dvalid=%b ferr=%b ovf=%b, required all zero",
                 bus.dout, bus.dvalid, bus.ferr, bus.overrun);
      end
    end
  endtask

  task automatic test_single;
    q.delete();
    push_frame(16'hA5C3, 1'b0, 1'b0);
    push_idle(3, 1'b0, 1'b0);
    push_idle(1, 1'b1, 1'b0);
    foreach (q[i]) begin
      tick(q[i]);
      n_vec++;
      if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {m_dout, m_dvalid, m_ferr, m_ovf}) begin
        n_err++;
        $display("FAIL single[%0d]: dout=%h dv=%b ferr=%b ovf=%b, required %h %b %b %b", i,
                 bus.dout, bus.dvalid, bus.ferr, bus.overrun, m_dout, m_dvalid, m_ferr, m_ovf);
      end
      if (i >= W - 1 && i < W + 2) begin
        n_vec++;
        if (!(bus.dvalid === 1'b1 && bus.dout === 16'hA5C3)) begin
          n_err++;
          $display("FAIL single_hold[%0d]: dv=%b dout=%h, required 1 a5c3", i, bus.dvalid, bus.dout);
        end
      end else if (i < W - 1 || i == W + 3) begin
        n_vec++;
        if (bus.dvalid !== 1'b0) begin
          n_err++;
          $display("FAIL single_dv[%0d]: dvalid=%b, required 0", i, bus.dvalid);
        end
      end
    end
  endtask

  task automatic test_stream;
    logic [W-1:0] got[$];
    logic [W-1:0] exp_w[3];
    int flags;
    exp_w = '{16'h0001, 16'h8000, 16'hFFFF};
    flags = 0;
    q.delete();
    foreach (exp_w[k]) push_frame(exp_w[k], 1'b1, 1'b0);
    push_idle(2, 1'b1, 1'b0);
    foreach (q[i]) begin
      tick(q[i]);
      n_vec++;
      if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {m_dout, m_dvalid, m_ferr, m_ovf}) begin
        n_err++;
        $display("FAIL stream[%0d]: dout=%h dv=%b ferr=%b ovf=%b, required %h %b %b %b", i,
                 bus.dout, bus.dvalid, bus.ferr, bus.overrun, m_dout, m_dvalid, m_ferr, m_ovf);
      end
      if (bus.dvalid === 1'b1) got.push_back(bus.dout);
      if (bus.ferr !== 1'b0 || bus.overrun !== 1'b0) flags++;
    end
    n_vec++;
    if (got.size() != 3 || flags != 0) begin
      n_err++;
      $display("FAIL stream_count: words=%0d flag_cycles=%0d, required 3 0", got.size(), flags);
    end else begin
      foreach (exp_w[k]) begin
        n_vec++;
        if (got[k] !== exp_w[k]) begin
          n_err++;
          $display("FAIL stream_word%0d: got %h, required %h", k, got[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_overrun;
    q.delete();
    push_frame(16'h1234, 1'b0, 1'b0);
    push_frame(16'h5678, 1'b0, 1'b0);
    foreach (q[i]) tick(q[i]);
    n_vec++;
    if ({bus.dout, bus.dvalid, bus.overrun} !== {16'h1234, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_set: dout=%h dv=%b ovf=%b, required 1234 1 1", bus.dout, bus.dvalid, bus.overrun);
    end
    tick('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    n_vec++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clr: ovf=%b, required 0", bus.overrun);
    end
    q.delete();
    push_frame(16'h9ABC, 1'b0, 1'b1);
    foreach (q[i]) tick(q[i]);
    n_vec++;
    if ({bus.dout, bus.overrun, m_ovf} !== {16'h1234, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_prio: dout=%h ovf=%b, required 1234 1", bus.dout, bus.overrun);
    end
    tick('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_framing(input int nbits);
    int ferr_cnt, first_dv;
    logic [W-1:0] first_word;
    ferr_cnt = 0;
    first_dv = -1;
    first_word = '0;
    q.delete();
    q.push_back('{1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0});
    push_idle(nbits - 1, 1'b1, 1'b0);
    push_frame(16'h00FF, 1'b1, 1'b0);
    push_idle(2, 1'b1, 1'b0);
    foreach (q[i]) begin
      tick(q[i]);
      n_vec++;
      if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {m_dout, m_dvalid, m_ferr, m_ovf}) begin
        n_err++;
        $display("FAIL frame%0d[%0d]: dout=%h dv=%b ferr=%b ovf=%b, required %h %b %b %b", nbits, i,
                 bus.dout, bus.dvalid, bus.ferr, bus.overrun, m_dout, m_dvalid, m_ferr, m_ovf);
      end
      if (bus.ferr === 1'b1) ferr_cnt++;
      if (bus.dvalid === 1'b1 && first_dv < 0) begin
        first_dv = i;
        first_word = bus.dout;
      end
    end
    n_vec++;
    if (ferr_cnt != 1 || first_dv != nbits + W - 1 || first_word !== 16'h00FF) begin
      n_err++;
      $display("FAIL frame%0d_sum: ferr_cycles=%0d dv_at=%0d word=%h, required 1 %0d 00ff",
               nbits, ferr_cnt, first_dv, first_word, nbits + W - 1);
    end
  endtask

  task automatic test_simul;
    q.delete();
    push_frame(16'hAAAA, 1'b0, 1'b0);
    push_frame(16'h5555, 1'b0, 1'b0);
    q[q.size() - 1].dready = 1'b1;
    foreach (q[i]) tick(q[i]);
    n_vec++;
    if ({bus.dout, bus.dvalid, bus.overrun} !== {16'h5555, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL simul: dout=%h dv=%b ovf=%b, required 5555 1 0", bus.dout, bus.dvalid, bus.overrun);
    end
    tick('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_reset_mid;
    int ferr_seen;
    ferr_seen = 0;
    q.delete();
    push_frame(16'h1111, 1'b0, 1'b0);
    push_frame(16'h2222, 1'b0, 1'b0);
    push_frame(16'($urandom), 1'b0, 1'b0);
    q = q[0:2*W+9];
    q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    foreach (q[i]) tick(q[i]);
    n_vec++;
    if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {(W+3)'(0)}) begin
      n_err++;
      $display("FAIL rst_mid: dout=%h dv=%b ferr=%b ovf=%b, required all zero",
               bus.dout, bus.dvalid, bus.ferr, bus.overrun);
    end
    q.delete();
    push_frame(16'h0F0F, 1'b0, 1'b0);
    foreach (q[i]) begin
      tick(q[i]);
      if (bus.ferr === 1'b1) ferr_seen++;
    end
    n_vec++;
    if ({bus.dout, bus.dvalid, bus.overrun} !== {16'h0F0F, 1'b1, 1'b0} || ferr_seen != 0) begin
      n_err++;
      $display("FAIL rst_resume: dout=%h dv=%b ovf=%b ferr_cycles=%0d, required 0f0f 1 0 0",
               bus.dout, bus.dvalid, bus.overrun, ferr_seen);
    end
    tick('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_random;
    stim_t s;
    for (int i = 0; i < 3000; i++) begin
      s.din    = 1'($urandom);
      s.isync  = ($urandom_range(0, 19) == 0);
      s.dready = 1'($urandom);
      s.clr    = ($urandom_range(0, 9) == 0);
      s.rst    = ($urandom_range(0, 199) == 0);
      tick(s);
      n_vec++;
      if ({bus.dout, bus.dvalid, bus.ferr, bus.overrun} !== {m_dout, m_dvalid, m_ferr, m_ovf}) begin
        n_err++;
        $display("FAIL random[%0d]: dout=%h dv=%b ferr=%b ovf=%b, required %h %b %b %b", i,
                 bus.dout, bus.dvalid, bus.ferr, bus.overrun, m_dout, m_dvalid, m_ferr, m_ovf);
      end
    end
  endtask

  initial begin
    bus.din = 0; bus.isync = 0; bus.dready = 0; bus.clr_ovf = 0; reset = 1;
    test_reset;
    test_single;
    test_stream;
    test_overrun;
    test_framing(7);
    test_framing(15);
    test_simul;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
